// File: rtl/vga_line_fetch_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_fetch_arbiter_if
// Brief    : Timing strobes, video-RAM bus, line-buffer and host port bundle
// Revision : 1.0
// ============================================================================
interface vga_line_fetch_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_frame_start;
    logic              i_line_start;
    logic [ADDR_W-1:0] i_fb_base;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              i_mem_ack;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_lb_we;
    logic [7:0]        o_lb_addr;
    logic [DATA_W-1:0] o_lb_wdata;
    logic              o_lb_bank;
    logic              o_disp_bank;

    logic              i_host_req;
    logic [ADDR_W-1:0] i_host_addr;
    logic [DATA_W-1:0] i_host_wdata;
    logic              o_host_ack;

    logic              o_underrun;
    logic [7:0]        o_underrun_count;

    modport slave (
        input  i_frame_start, i_line_start, i_fb_base,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_ack, i_mem_rdata,
        output o_lb_we, o_lb_addr, o_lb_wdata, o_lb_bank, o_disp_bank,
        input  i_host_req, i_host_addr, i_host_wdata,
        output o_host_ack, o_underrun, o_underrun_count
    );

    modport master (
        output i_frame_start, i_line_start, i_fb_base,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_ack, i_mem_rdata,
        input  o_lb_we, o_lb_addr, o_lb_wdata, o_lb_bank, o_disp_bank,
        output i_host_req, i_host_addr, i_host_wdata,
        input  o_host_ack, o_underrun, o_underrun_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_line_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_fetch_arbiter
// Brief    : Bursts one framebuffer line per line strobe into a ping-pong line
//            buffer and arbitrates the single-port video RAM with a host writer
// Revision : 1.0
// ============================================================================
module vga_line_fetch_arbiter #(
    parameter int HPIX         = 800,
    parameter int PIX_PER_WORD = 4,
    parameter int LINE_WORDS   = HPIX / PIX_PER_WORD,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16
) (
    input  wire logic               i_clock,
    input  wire logic               i_btn_reset,
    vga_line_fetch_arbiter_if.slave bus
);
    localparam logic [1:0]        ST_IDLE   = 2'd0;
    localparam logic [1:0]        ST_FETCH  = 2'd1;
    localparam logic [1:0]        ST_HOST   = 2'd2;
    localparam logic [1:0]        ST_DRAIN  = 2'd3;
    localparam logic [7:0]        LAST_IDX  = 8'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_WORDS);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] row_ptr_q;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic [7:0]        idx_q;
    logic              fetch_pending_q;
    logic              lb_bank_q;
    logic              lb_we_q;
    logic [7:0]        lb_addr_q;
    logic [DATA_W-1:0] lb_wdata_q;
    logic [ADDR_W-1:0] host_addr_q;
    logic [DATA_W-1:0] host_wdata_q;
    logic [ADDR_W-1:0] drain_addr_q;
    logic              underrun_q;
    logic [7:0]        underrun_cnt_q;

    logic [ADDR_W-1:0] w_row_base;
    logic [ADDR_W-1:0] w_fetch_word_addr;
    logic              w_fetch_incomplete;
    logic              w_fetch_ack;
    logic              w_grant_host;

    // A frame strobe coincident with a line strobe makes that line use the new base
    assign w_row_base         = bus.i_frame_start ? bus.i_fb_base : row_ptr_q;
    assign w_fetch_word_addr  = fetch_addr_q + ADDR_W'(idx_q);
    assign w_fetch_incomplete = (state_q == ST_FETCH) || fetch_pending_q;
    assign w_fetch_ack        = (state_q == ST_FETCH) && bus.i_mem_ack;
    assign w_grant_host       = (state_q == ST_IDLE) && !fetch_pending_q && bus.i_host_req;

    always_ff @(posedge i_clock or negedge i_btn_reset) begin
        if (!i_btn_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An aborted fetch whose read is still outstanding parks in DRAIN so the
    // request stays stable until the RAM acks; that data is then dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_pending_q) begin
                    state_d = ST_FETCH;
                end else if (bus.i_host_req) begin
                    state_d = ST_HOST;
                end
            end
            ST_FETCH: begin
                if (bus.i_line_start) begin
                    state_d = bus.i_mem_ack ? ST_IDLE : ST_DRAIN;
                end else if (bus.i_mem_ack && (idx_q == LAST_IDX)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOST, ST_DRAIN: begin
                if (bus.i_mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_mem_req   = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_host_ack  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.o_mem_req  = 1'b1;
                bus.o_mem_addr = w_fetch_word_addr;
            end
            ST_HOST: begin
                bus.o_mem_req   = 1'b1;
                bus.o_mem_we    = 1'b1;
                bus.o_mem_addr  = host_addr_q;
                bus.o_mem_wdata = host_wdata_q;
                bus.o_host_ack  = bus.i_mem_ack;
            end
            ST_DRAIN: begin
                bus.o_mem_req  = 1'b1;
                bus.o_mem_addr = drain_addr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_btn_reset) begin
        if (!i_btn_reset) begin
            row_ptr_q       <= '0;
            fetch_addr_q    <= '0;
            idx_q           <= '0;
            fetch_pending_q <= 1'b0;
            lb_bank_q       <= 1'b0;
            lb_we_q         <= 1'b0;
            lb_addr_q       <= '0;
            lb_wdata_q      <= '0;
            host_addr_q     <= '0;
            host_wdata_q    <= '0;
            drain_addr_q    <= '0;
            underrun_q      <= 1'b0;
            underrun_cnt_q  <= '0;
        end else begin
            lb_we_q    <= w_fetch_ack && !bus.i_line_start;
            underrun_q <= bus.i_line_start && w_fetch_incomplete;

            if (w_fetch_ack && !bus.i_line_start) begin
                lb_addr_q  <= idx_q;
                lb_wdata_q <= bus.i_mem_rdata;
            end

            if (bus.i_frame_start) begin
                row_ptr_q <= bus.i_fb_base;
            end

            if (bus.i_line_start) begin
                fetch_addr_q    <= w_row_base;
                row_ptr_q       <= w_row_base + LINE_STEP;
                idx_q           <= '0;
                lb_bank_q       <= ~lb_bank_q;
                fetch_pending_q <= 1'b1;
                if (w_fetch_incomplete && (underrun_cnt_q != 8'hFF)) begin
                    underrun_cnt_q <= underrun_cnt_q + 8'd1;
                end
            end else if (w_fetch_ack) begin
                idx_q <= idx_q + 8'd1;
                if (idx_q == LAST_IDX) begin
                    fetch_pending_q <= 1'b0;
                end
            end

            if ((state_q == ST_FETCH) && bus.i_line_start && !bus.i_mem_ack) begin
                drain_addr_q <= w_fetch_word_addr;
            end

            if (w_grant_host) begin
                host_addr_q  <= bus.i_host_addr;
                host_wdata_q <= bus.i_host_wdata;
            end
        end
    end

    assign bus.o_lb_we          = lb_we_q;
    assign bus.o_lb_addr        = lb_addr_q;
    assign bus.o_lb_wdata       = lb_wdata_q;
    assign bus.o_lb_bank        = lb_bank_q;
    assign bus.o_disp_bank      = ~lb_bank_q;
    assign bus.o_underrun       = underrun_q;
    assign bus.o_underrun_count = underrun_cnt_q;

endmodule
`default_nettype wire
